// File: rtl/wb_arbiter.sv
// Writeback arbiter: muxes the in-order pipeline result and NUM_AUX long-latency channels onto one
// registered register-file write port. Define WB_LOAD_EXT_EN to extract and extend sub-word loads.
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int NUM_AUX      = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pipe_valid,
    output logic                    pipe_ready,
    input  logic [1:0]              pipe_wb_sel,
    input  logic [XLEN-1:0]         pipe_opr_res,
    input  logic [XLEN-1:0]         pipe_dmem_rdata,
    input  logic [XLEN-1:0]         pipe_pc4,
    input  logic [2:0]              pipe_ld_fmt,
    input  logic [1:0]              pipe_byte_off,
    input  logic [4:0]              pipe_rd,
    input  logic                    pipe_rf_en,
    input  logic [NUM_AUX-1:0]      aux_valid,
    output logic [NUM_AUX-1:0]      aux_ready,
    input  logic [5*NUM_AUX-1:0]    aux_rd,
    input  logic [XLEN*NUM_AUX-1:0] aux_data,
    output logic                    rf_we,
    output logic [4:0]              rf_rd,
    output logic [XLEN-1:0]         rf_wdata
);

    localparam int PTR_W = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_AUX
    } gnt_e;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [AGE_W-1:0] age_q [NUM_AUX];
    logic [AGE_W-1:0] age_d [NUM_AUX];
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;

    gnt_e             gnt_kind;
    logic [PTR_W-1:0] gnt_idx;
    logic             starve_hit, rr_hit;
    logic [PTR_W-1:0] starve_idx, rr_idx;
    int               scan_idx;
    logic [XLEN-1:0]  load_data, pipe_data, aux_sel_data;
    logic [4:0]       aux_sel_rd;

    // Both searches walk the channels in round-robin order starting at rr_ptr.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        starve_hit = 1'b0;
        rr_hit     = 1'b0;
        starve_idx = '0;
        rr_idx     = '0;
        scan_idx   = 0;
        for (int k = 0; k < NUM_AUX; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_AUX;
            if (!starve_hit && aux_valid[scan_idx] && age_q[scan_idx] == AGE_MAX) begin
                starve_hit = 1'b1;
                starve_idx = PTR_W'(scan_idx);
            end
            if (!rr_hit && aux_valid[scan_idx]) begin
                rr_hit = 1'b1;
                rr_idx = PTR_W'(scan_idx);
            end
        end

        gnt_kind = GNT_NONE;
        gnt_idx  = '0;
        if (starve_hit) begin
            gnt_kind = GNT_AUX;
            gnt_idx  = starve_idx;
        end else if (pipe_valid) begin
            gnt_kind = GNT_PIPE;
        end else if (rr_hit) begin
            gnt_kind = GNT_AUX;
            gnt_idx  = rr_idx;
        end
    end

    always_comb begin
        pipe_ready   = (gnt_kind == GNT_PIPE);
        aux_ready    = '0;
        aux_sel_rd   = '0;
        aux_sel_data = '0;
        for (int i = 0; i < NUM_AUX; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                aux_ready[i] = (gnt_kind == GNT_AUX);
                aux_sel_rd   = aux_rd[5*i +: 5];
                aux_sel_data = aux_data[XLEN*i +: XLEN];
            end
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = pipe_dmem_rdata[8*pipe_byte_off +: 8];
        ld_half = pipe_dmem_rdata[16*pipe_byte_off[1] +: 16];
        case (pipe_ld_fmt)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_data = XLEN'(ld_byte);
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_data = XLEN'(ld_half);
            default: load_data = pipe_dmem_rdata;
        endcase
    end
`else
    // Alignment belongs to the load unit in this build; format and offset are deliberately unused.
    logic unused_ld_fields;
    assign unused_ld_fields = ^{pipe_ld_fmt, pipe_byte_off};
    assign load_data        = pipe_dmem_rdata;
`endif

    always_comb begin
        case (pipe_wb_sel)
            2'b00:   pipe_data = pipe_opr_res;
            2'b01:   pipe_data = load_data;
            2'b10:   pipe_data = pipe_pc4;
            default: pipe_data = '0;
        endcase
    end

    // A transfer to x0 is consumed but never writes; rd/wdata still track the accepted transfer.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        for (int i = 0; i < NUM_AUX; i++) begin
            if (!aux_valid[i] || (gnt_kind == GNT_AUX && gnt_idx == PTR_W'(i))) begin
                age_d[i] = '0;
            end else if (age_q[i] == AGE_MAX) begin
                age_d[i] = age_q[i];
            end else begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
        case (gnt_kind)
            GNT_PIPE: begin
                rf_we_d    = pipe_rf_en && (pipe_rd != 5'd0);
                rf_rd_d    = pipe_rd;
                rf_wdata_d = pipe_data;
            end
            GNT_AUX: begin
                rf_we_d    = (aux_sel_rd != 5'd0);
                rf_rd_d    = aux_sel_rd;
                rf_wdata_d = aux_sel_data;
                rr_ptr_d   = (gnt_idx == PTR_W'(NUM_AUX - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            // NOTE: the age array is only NUM_AUX flops, not a RAM, so it is reset like any other state.
            for (int i = 0; i < NUM_AUX; i++) age_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            for (int i = 0; i < NUM_AUX; i++) age_q[i] <= age_d[i];
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a priority/aging reference model predicts grants and write-port
// values; a monitor process compares the registered write port one cycle after each prediction.
module tb_wb_arbiter;
    localparam int XLEN = 32;
    localparam int NA   = 3;
    localparam int SL   = 8;

    logic            clk, rst_n;
    logic            pipe_valid, pipe_ready, pipe_rf_en;
    logic [1:0]      pipe_wb_sel, pipe_byte_off;
    logic [XLEN-1:0] pipe_opr_res, pipe_dmem_rdata, pipe_pc4;
    logic [2:0]      pipe_ld_fmt;
    logic [4:0]      pipe_rd;
    logic [NA-1:0]   aux_valid, aux_ready;
    logic [5*NA-1:0] aux_rd;
    logic [XLEN*NA-1:0] aux_data;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;

    wb_arbiter #(.XLEN(XLEN), .NUM_AUX(NA), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_wb_sel(pipe_wb_sel),
        .pipe_opr_res(pipe_opr_res), .pipe_dmem_rdata(pipe_dmem_rdata), .pipe_pc4(pipe_pc4),
        .pipe_ld_fmt(pipe_ld_fmt), .pipe_byte_off(pipe_byte_off), .pipe_rd(pipe_rd),
        .pipe_rf_en(pipe_rf_en), .aux_valid(aux_valid), .aux_ready(aux_ready),
        .aux_rd(aux_rd), .aux_data(aux_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [1:0]  sel;
        logic [31:0] opr, rdata, pc4;
        logic [2:0]  fmt;
        logic [1:0]  off;
        logic [4:0]  rd;
        bit          en;
    } pipe_t;

    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          cmp;
    } exp_t;

    pipe_t       p;
    bit          av [NA];
    logic [4:0]  ard [NA];
    logic [31:0] adat [NA];

    int          age [NA];
    int          rr;
    bit          last_known;
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    exp_t        sb [$];
    int          n_checks, n_err;
    int          pipe_pct;

    logic        s_pr, s_we;
    logic [NA-1:0] s_ar;
    logic [4:0]  s_rd;
    logic [31:0] s_data;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_val(pipe_t t);
`ifdef WB_LOAD_EXT_EN
        logic [31:0] b, h;
        b = (t.rdata >> (8 * t.off)) & 32'hFF;
        h = (t.rdata >> (16 * t.off[1])) & 32'hFFFF;
        case (t.fmt)
            3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return t.rdata;
        endcase
`else
        return t.rdata;
`endif
    endfunction

    function automatic logic [31:0] pipe_wdata(pipe_t t);
        case (t.sel)
            2'd0:    return t.opr;
            2'd1:    return load_val(t);
            2'd2:    return t.pc4;
            default: return 32'd0;
        endcase
    endfunction

    // Returns the granted aux channel, NA for the pipeline, or -1 for no grant.
    function automatic int model_grant();
        for (int k = 0; k < NA; k++)
            if (av[(rr + k) % NA] && age[(rr + k) % NA] == SL) return (rr + k) % NA;
        if (p.v) return NA;
        for (int k = 0; k < NA; k++)
            if (av[(rr + k) % NA]) return (rr + k) % NA;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) age[i] = 0;
        rr         = 0;
        last_known = 1'b1;
        last_rd    = '0;
        last_data  = '0;
        sb.delete();
    endtask

    task automatic drive();
        pipe_valid      = p.v;
        pipe_wb_sel     = p.sel;
        pipe_opr_res    = p.opr;
        pipe_dmem_rdata = p.rdata;
        pipe_pc4        = p.pc4;
        pipe_ld_fmt     = p.fmt;
        pipe_byte_off   = p.off;
        pipe_rd         = p.rd;
        pipe_rf_en      = p.en;
        for (int i = 0; i < NA; i++) begin
            aux_valid[i]          = av[i];
            aux_rd[5*i +: 5]      = ard[i];
            aux_data[32*i +: 32]  = adat[i];
        end
    endtask

    function automatic logic [4:0] rand_rd();
        return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    endfunction

    task automatic rand_pipe();
        p.v     = 1'b1;
        p.sel   = 2'($urandom);
        p.opr   = $urandom;
        p.rdata = $urandom;
        p.pc4   = $urandom;
        p.fmt   = 3'($urandom);
        p.off   = 2'($urandom);
        p.rd    = rand_rd();
        p.en    = ($urandom_range(0, 9) != 0);
    endtask

    task automatic rand_aux(int i);
        av[i]   = 1'b1;
        ard[i]  = rand_rd();
        adat[i] = $urandom;
    endtask

    task automatic randomize_sources();
        if (!p.v && $urandom_range(0, 99) < pipe_pct) rand_pipe();
        for (int i = 0; i < NA; i++)
            if (!av[i] && $urandom_range(0, 99) < 40) rand_aux(i);
    endtask

    // One clock cycle: drive at negedge, predict and check readies, queue the expected write,
    // advance the model, then return the write port as seen just after the edge.
    task automatic step(output logic o_pr, output logic [NA-1:0] o_ar, output logic o_we,
                        output logic [4:0] o_rd, output logic [31:0] o_data);
        int            g;
        exp_t          e;
        logic [NA-1:0] ear;
        @(negedge clk);
        drive();
        #1;
        g   = model_grant();
        ear = '0;
        if (g >= 0 && g < NA) ear[g] = 1'b1;
        o_pr = pipe_ready;
        o_ar = aux_ready;
        check("pipe_ready", pipe_ready, (g == NA));
        check("aux_ready", aux_ready, ear);
        e.we   = 1'b0;
        e.rd   = last_rd;
        e.data = last_data;
        e.cmp  = last_known;
        if (g == NA) begin
            e.we   = p.en && (p.rd != 0);
            e.rd   = p.rd;
            e.data = pipe_wdata(p);
        end else if (g >= 0) begin
            e.we   = (ard[g] != 0);
            e.rd   = ard[g];
            e.data = adat[g];
        end
        if (g >= 0) begin
            e.cmp      = e.we;
            last_known = e.we;
            last_rd    = e.rd;
            last_data  = e.data;
        end
        sb.push_back(e);
        for (int i = 0; i < NA; i++)
            age[i] = (!av[i] || i == g) ? 0 : ((age[i] < SL) ? age[i] + 1 : SL);
        if (g >= 0 && g < NA) rr = (g + 1) % NA;
        if (g == NA) p.v = 1'b0;
        else if (g >= 0) av[g] = 1'b0;
        @(posedge clk);
        #2;
        o_we   = rf_we;
        o_rd   = rf_rd;
        o_data = rf_wdata;
    endtask

    task automatic drain();
        bit pending;
        pending = 1'b1;
        for (int k = 0; k < 40 && pending; k++) begin
            pending = p.v;
            for (int i = 0; i < NA; i++) pending |= av[i];
            if (pending) step(s_pr, s_ar, s_we, s_rd, s_data);
        end
        check("drain_done", pending, 0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_we"}, rf_we, 0);
        check({tag, "_rd"}, rf_rd, 0);
        check({tag, "_wdata"}, rf_wdata, 0);
    endtask

    // Monitor: consumes one prediction per active cycle, just after the edge that registers it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                check("rf_we", rf_we, e.we);
                if (e.cmp) begin
                    check("rf_rd", rf_rd, e.rd);
                    check("rf_wdata", rf_wdata, e.data);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        pipe_pct = 50;
        p        = '{default: '0};
        for (int i = 0; i < NA; i++) begin
            av[i]   = 1'b0;
            ard[i]  = '0;
            adat[i] = '0;
        end
        rst_n = 1'b0;
        drive();
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("init_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        repeat (300) begin
            randomize_sources();
            step(s_pr, s_ar, s_we, s_rd, s_data);
        end

        // Reset in the middle of traffic with every source requesting.
        if (!p.v) rand_pipe();
        for (int i = 0; i < NA; i++) if (!av[i]) rand_aux(i);
        @(negedge clk);
        drive();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midop_reset");
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs("reset_held");
        end
        p.v = 1'b0;
        av[2] = 1'b0;
        av[0] = 1'b1; ard[0] = 5'd3; adat[0] = $urandom;
        av[1] = 1'b1; ard[1] = 5'd4; adat[1] = $urandom;
        drive();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Round-robin between aux0 (rd 3) and aux1 (rd 4); first grant after reset is aux0.
        for (int c = 0; c < 4; c++) begin
            if (!av[0]) begin av[0] = 1'b1; ard[0] = 5'd3; adat[0] = $urandom; end
            if (!av[1]) begin av[1] = 1'b1; ard[1] = 5'd4; adat[1] = $urandom; end
            step(s_pr, s_ar, s_we, s_rd, s_data);
            if (c == 0) check("first_grant_aux0", s_ar, 3'b001);
            check("rr_we", s_we, 1);
            check("rr_rd", s_rd, (c % 2 == 0) ? 3 : 4);
        end
        drain();

        // Starvation: pipeline always valid, aux0 waits SL cycles and then takes one slot.
        av[0] = 1'b1; ard[0] = 5'd7; adat[0] = $urandom;
        for (int c = 0; c < 10; c++) begin
            if (!p.v) rand_pipe();
            step(s_pr, s_ar, s_we, s_rd, s_data);
            check("starve_pipe_ready", s_pr, (c != 8));
            check("starve_aux0_ready", s_ar[0], (c == 8));
        end
        drain();

        // Transfer to x0 is accepted without a write.
        av[0] = 1'b1; ard[0] = 5'd0; adat[0] = 32'hDEAD_BEEF;
        step(s_pr, s_ar, s_we, s_rd, s_data);
        check("zero_rd_ready", s_ar[0], 1);
        check("zero_rd_we", s_we, 0);

        p = '{v: 1'b1, sel: 2'b01, opr: 32'h0, rdata: 32'h0000_80FF, pc4: 32'h0,
              fmt: 3'b000, off: 2'd1, rd: 5'd5, en: 1'b1};
`ifdef WB_LOAD_EXT_EN
        step(s_pr, s_ar, s_we, s_rd, s_data);
        check("lb_we", s_we, 1);
        check("lb_rd", s_rd, 5);
        check("lb_wdata", s_data, 32'hFFFF_FF80);
        p.v   = 1'b1;
        p.fmt = 3'b100;
        step(s_pr, s_ar, s_we, s_rd, s_data);
        check("lbu_wdata", s_data, 32'h0000_0080);
`else
        p.fmt   = 3'b001;
        p.rdata = 32'h8001_7FFE;
        p.off   = 2'd2;
        step(s_pr, s_ar, s_we, s_rd, s_data);
        check("raw_load_we", s_we, 1);
        check("raw_load_wdata", s_data, 32'h8001_7FFE);
`endif

        for (int c = 0; c < 2000; c++) begin
            pipe_pct = (c < 1000) ? 50 : 95;
            randomize_sources();
            step(s_pr, s_ar, s_we, s_rd, s_data);
        end
        drain();
        step(s_pr, s_ar, s_we, s_rd, s_data);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
